// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Provides occupancy encodings, the NOP control word and default widths.
package mips_pipe_pkg;

   localparam int NB_REG  = 32;
   localparam int NB_CTRL = 16;

   typedef logic [1:0] occ_t;

   localparam occ_t OCC_EMPTY = 2'd0;
   localparam occ_t OCC_ONE   = 2'd1;
   localparam occ_t OCC_FULL  = 2'd2;

   // An all-zero control word is a NOP for the execute stage.
   localparam logic [NB_CTRL-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: valid flag, control word and payload register.
// Latency: 1 cycle from load to output.
// Backpressure: none internally; the parent decides when to load or clear.
//
// Ports: clk/rst (async active-high), en freezes the slot, load captures
// d_data/d_ctrl and sets valid, clr drops valid and zeroes the control word
// (payload is held). clr has priority over load.
module pipe_stage_slot #(
   parameter int NB_DATA = 128,
   parameter int NB_CTRL = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               load,
   input  logic               clr,
   input  logic [NB_DATA-1:0] d_data,
   input  logic [NB_CTRL-1:0] d_ctrl,
   output logic               q_valid,
   output logic [NB_DATA-1:0] q_data,
   output logic [NB_CTRL-1:0] q_ctrl
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_valid <= 1'b0;
         q_data  <= '0;
         q_ctrl  <= '0;
      end else if (en) begin
         if (clr) begin
            q_valid <= 1'b0;
            q_ctrl  <= '0;
         end else if (load) begin
            q_valid <= 1'b1;
            q_data  <= d_data;
            q_ctrl  <= d_ctrl;
         end
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush and debug freeze.
// Latency: 1 cycle push to o_valid; full throughput with i_ready held high.
// Backpressure: o_ready is registered (no combinational path from i_ready); drops only when both slots are full.
//
// Ports: i_clk, i_reset (async active-high), i_dunit_clk_en (0 freezes all state),
// i_flush, upstream i_valid/o_ready/i_data/i_ctrl, downstream o_valid/i_ready/o_data/o_ctrl,
// o_occupancy. Defining PIPE_STAGE_PERF_EN adds saturating o_stall_cnt, o_bubble_cnt,
// o_flush_cnt (NB_CNT bits each).
module pipe_stage_elastic #(
   parameter int NB_DATA = 4 * mips_pipe_pkg::NB_REG,
   parameter int NB_CTRL = mips_pipe_pkg::NB_CTRL
`ifdef PIPE_STAGE_PERF_EN
   ,
   parameter int NB_CNT  = 32
`endif
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_dunit_clk_en,
   input  logic               i_flush,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [NB_DATA-1:0] i_data,
   input  logic [NB_CTRL-1:0] i_ctrl,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NB_DATA-1:0] o_data,
   output logic [NB_CTRL-1:0] o_ctrl,
   output logic [1:0]         o_occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [NB_CNT-1:0]  o_stall_cnt,
   output logic [NB_CNT-1:0]  o_bubble_cnt,
   output logic [NB_CNT-1:0]  o_flush_cnt
`endif
);
   import mips_pipe_pkg::*;

   logic               en;
   logic               push;
   logic               pop;
   occ_t               occ;
   occ_t               occ_nxt;
   logic               ready_q;

   logic               head_load;
   logic               head_clr;
   logic               head_from_skid;
   logic               skid_load;
   logic               skid_clr;

   logic               head_valid;
   logic [NB_DATA-1:0] head_data;
   logic [NB_CTRL-1:0] head_ctrl;
   logic               skid_valid;
   logic [NB_DATA-1:0] skid_data;
   logic [NB_CTRL-1:0] skid_ctrl;

   assign en   = i_dunit_clk_en;
   assign push = i_valid & ready_q & en;
   assign pop  = head_valid & i_ready & en;

   always_comb begin
      occ_nxt        = occ;
      head_load      = 1'b0;
      head_clr       = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (i_flush) begin
         // Flush kills both slots and overrides any same-cycle push/pop.
         occ_nxt  = OCC_EMPTY;
         head_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (occ)
            OCC_EMPTY: begin
               if (push) begin
                  head_load = 1'b1;
                  occ_nxt   = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (push && pop) begin
                  head_load = 1'b1;
               end else if (push) begin
                  skid_load = 1'b1;
                  occ_nxt   = OCC_FULL;
               end else if (pop) begin
                  head_clr = 1'b1;
                  occ_nxt  = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               // Skid entry advances into the head; upstream is held off by o_ready=0.
               if (pop && skid_valid) begin
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  occ_nxt        = OCC_ONE;
               end
            end
            default: begin
               occ_nxt  = OCC_EMPTY;
               head_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         occ     <= OCC_EMPTY;
         ready_q <= 1'b1;
      end else if (en) begin
         occ     <= occ_nxt;
         ready_q <= (occ_nxt != OCC_FULL);
      end
   end

   pipe_stage_slot #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL)) u_head (
      .clk     (i_clk),
      .rst     (i_reset),
      .en      (en),
      .load    (head_load),
      .clr     (head_clr),
      .d_data  (head_from_skid ? skid_data : i_data),
      .d_ctrl  (head_from_skid ? skid_ctrl : i_ctrl),
      .q_valid (head_valid),
      .q_data  (head_data),
      .q_ctrl  (head_ctrl)
   );

   pipe_stage_slot #(.NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL)) u_skid (
      .clk     (i_clk),
      .rst     (i_reset),
      .en      (en),
      .load    (skid_load),
      .clr     (skid_clr),
      .d_data  (i_data),
      .d_ctrl  (i_ctrl),
      .q_valid (skid_valid),
      .q_data  (skid_data),
      .q_ctrl  (skid_ctrl)
   );

   assign o_ready     = ready_q;
   assign o_valid     = head_valid;
   assign o_occupancy = occ;
   // Masking guarantees the next stage sees a NOP bubble when nothing is valid.
   assign o_data      = head_valid ? head_data : '0;
   assign o_ctrl      = head_valid ? head_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_stall_cnt  <= '0;
         o_bubble_cnt <= '0;
         o_flush_cnt  <= '0;
      end else if (en) begin
         if (head_valid && !i_ready && (o_stall_cnt != '1))
            o_stall_cnt <= o_stall_cnt + 1'b1;
         if (!head_valid && (o_bubble_cnt != '1))
            o_bubble_cnt <= o_bubble_cnt + 1'b1;
         if (i_flush && (o_flush_cnt != '1))
            o_flush_cnt <= o_flush_cnt + 1'b1;
      end
   end
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios followed by random traffic.
// The reference model is an ordered queue of accepted entries (capacity 2).
// A negedge monitor compares the DUT's outputs against the model head and size.
module tb_pipe_stage_elastic;

   localparam int NB_DATA = 128;
   localparam int NB_CTRL = 16;

   typedef struct packed {
      logic [NB_DATA-1:0] d;
      logic [NB_CTRL-1:0] c;
   } ent_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               flush = 1'b0;
   logic               vin = 1'b0;
   logic               rdy_in = 1'b0;
   logic [NB_DATA-1:0] din = '0;
   logic [NB_CTRL-1:0] cin = '0;
   logic               o_ready;
   logic               o_valid;
   logic [NB_DATA-1:0] o_data;
   logic [NB_CTRL-1:0] o_ctrl;
   logic [1:0]         o_occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]        stall_cnt;
   logic [31:0]        bubble_cnt;
   logic [31:0]        flush_cnt;
`endif

   ent_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   mon_on = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_elastic dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_dunit_clk_en (en),
      .i_flush        (flush),
      .i_valid        (vin),
      .o_ready        (o_ready),
      .i_data         (din),
      .i_ctrl         (cin),
      .o_valid        (o_valid),
      .i_ready        (rdy_in),
      .o_data         (o_data),
      .o_ctrl         (o_ctrl),
      .o_occupancy    (o_occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .o_stall_cnt    (stall_cnt),
      .o_bubble_cnt   (bubble_cnt),
      .o_flush_cnt    (flush_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [NB_DATA-1:0] act, input logic [NB_DATA-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus, then advance the model by the rules of the stage:
   // capacity 2, FIFO order, flush empties it, a frozen cycle changes nothing.
   task automatic step(input bit v, input bit r, input bit e, input bit f,
                       input logic [NB_DATA-1:0] d, input logic [NB_CTRL-1:0] c);
      int  sz;
      bit  do_pop;
      bit  do_push;
      ent_t ent;
      vin = v; rdy_in = r; en = e; flush = f; din = d; cin = c;
      @(posedge clk);
      sz = exp_q.size();
      if (e && !rst) begin
         if (f) begin
            exp_q.delete();
         end else begin
            do_pop  = (sz > 0) && r;
            do_push = v && (sz < 2);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
               ent.d = d;
               ent.c = c;
               exp_q.push_back(ent);
            end
         end
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         chk("occupancy", o_occupancy, exp_q.size());
         chk("o_ready", o_ready, exp_q.size() < 2);
         chk("o_valid", o_valid, exp_q.size() > 0);
         if (exp_q.size() > 0) begin
            chk("o_data", o_data, exp_q[0].d);
            chk("o_ctrl", o_ctrl, exp_q[0].c);
         end else begin
            chk("o_data_masked", o_data, '0);
            chk("o_ctrl_masked", o_ctrl, '0);
         end
      end
   end

   function automatic logic [NB_DATA-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_on = 1'b1;

      // Streaming with downstream always ready.
      step(1, 1, 1, 0, 128'h1, 16'h0101);
      step(1, 1, 1, 0, 128'h2, 16'h0202);
      step(1, 1, 1, 0, 128'h3, 16'h0303);
      step(0, 1, 1, 0, '0, '0);
      step(0, 1, 1, 0, '0, '0);

      // Backpressure fills both slots, then drain.
      step(1, 0, 1, 0, 128'h10, 16'h0010);
      step(1, 0, 1, 0, 128'h11, 16'h0011);
      step(1, 0, 1, 0, 128'h12, 16'h0012);
      step(0, 1, 1, 0, '0, '0);
      step(0, 1, 1, 0, '0, '0);
      step(0, 1, 1, 0, '0, '0);

      // Flush while full, with push and pop requested in the same cycle.
      step(1, 0, 1, 0, 128'h20, 16'h1234);
      step(1, 0, 1, 0, 128'h21, 16'h5678);
      step(1, 1, 1, 1, 128'hDEAD, 16'hBEEF);
      step(0, 1, 1, 0, '0, '0);

      // Debug freeze with both handshakes asserted.
      step(1, 0, 1, 0, 128'h30, 16'h0030);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 128'h40 + 128'(i), 16'h0040);
      step(1, 1, 1, 0, 128'h31, 16'h0031);
      step(0, 1, 1, 0, '0, '0);
      step(0, 1, 1, 0, '0, '0);

      // Asynchronous reset while holding two entries.
      step(1, 0, 1, 0, 128'hA5, 16'h00A5);
      step(1, 0, 1, 0, 128'hA5, 16'h00A5);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_o_ready", o_ready, 1'b1);
      chk("rst_occupancy", o_occupancy, 2'd0);
      chk("rst_o_ctrl", o_ctrl, '0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 10) < 7, ($urandom % 10) < 6, ($urandom % 10) < 9,
              ($urandom % 32) == 0, rand_data(), NB_CTRL'($urandom));
      end
      step(0, 1, 1, 0, '0, '0);
      step(0, 1, 1, 0, '0, '0);
      @(negedge clk);
      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
